// File: rtl/alu_muldiv_seq_if.sv
// Request and shared-ALU signal bundle for the sequential multiply/divide controller.
// The master side is the requester together with the shared ALU. The slave side is
// the controller.
interface alu_muldiv_seq_if #(
    parameter int N = 32
);
    // request / result port
    logic         valid_i;
    logic         ready_o;
    logic         op_i;
    logic [N-1:0] a_i;
    logic [N-1:0] b_i;
    logic         done_o;
    logic [N-1:0] res_hi_o;
    logic [N-1:0] res_lo_o;

    // shared ALU port
    logic         alu_own_o;
    logic [N-1:0] alu_a_o;
    logic [N-1:0] alu_b_o;
    logic         alu_c_o;
    logic [3:0]   alu_ope_o;
    logic [N-1:0] alu_sal_i;
    logic         alu_co_i;

    modport master (
        output valid_i, op_i, a_i, b_i, alu_sal_i, alu_co_i,
        input  ready_o, done_o, res_hi_o, res_lo_o,
               alu_own_o, alu_a_o, alu_b_o, alu_c_o, alu_ope_o
    );

    modport slave (
        input  valid_i, op_i, a_i, b_i, alu_sal_i, alu_co_i,
        output ready_o, done_o, res_hi_o, res_lo_o,
               alu_own_o, alu_a_o, alu_b_o, alu_c_o, alu_ope_o
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply (shift-add) and divide (restoring) controller.
// It borrows the shared N-bit ALU for one iteration per clock.
// Registers are shared between the two operations:
//   hi_reg  = acc (MULU) / rem (DIVU)
//   lo_reg  = mlr (MULU) / quo (DIVU)
//   opb_reg = mcd (MULU) / dvs (DIVU)
module alu_muldiv_seq #(
    parameter int         N       = 32,
    parameter logic [3:0] OPC_ADD = 4'b0010
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    alu_muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(N);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_reg;
    logic [CW-1:0] cnt_reg;
    logic          op_reg;
    logic [N-1:0]  hi_reg;
    logic [N-1:0]  lo_reg;
    logic [N-1:0]  opb_reg;
    logic [N-1:0]  res_hi_reg;
    logic [N-1:0]  res_lo_reg;
    logic [N-1:0]  alu_a_reg;
    logic [N-1:0]  alu_b_reg;
    logic          alu_c_reg;

    logic          in_calc;
    logic          last_iter;
    logic [N-1:0]  shifted;
    logic          div_ok;
    logic [N-1:0]  drv_a;
    logic [N-1:0]  drv_b;
    logic          drv_c;
    logic [N-1:0]  hi_next;
    logic [N-1:0]  lo_next;

    assign in_calc   = (state_reg == ST_CALC);
    assign last_iter = (cnt_reg == CW'(N - 1));

    // Operand selection and next-iteration values for both algorithms.
    // The shifted-out top remainder bit counts as a borrow-free subtraction.
    always_comb begin
        shifted = {hi_reg[N-2:0], lo_reg[N-1]};
        div_ok  = hi_reg[N-1] | bus.alu_co_i;
        drv_a   = hi_reg;
        drv_b   = lo_reg[0] ? opb_reg : '0;
        drv_c   = 1'b0;
        hi_next = {bus.alu_co_i, bus.alu_sal_i[N-1:1]};
        lo_next = {bus.alu_sal_i[0], lo_reg[N-1:1]};
        if (op_reg) begin
            drv_a   = shifted;
            drv_b   = opb_reg;
            drv_c   = 1'b1;
            hi_next = div_ok ? bus.alu_sal_i : shifted;
            lo_next = {lo_reg[N-2:0], div_ok};
        end
    end

    // Outputs: while iterating, drive the ALU live. Otherwise hold the last driven operands.
    assign bus.ready_o   = (state_reg == ST_IDLE);
    assign bus.done_o    = (state_reg == ST_DONE);
    assign bus.alu_own_o = in_calc;
    assign bus.alu_ope_o = OPC_ADD;
    assign bus.alu_a_o   = in_calc ? drv_a : alu_a_reg;
    assign bus.alu_b_o   = in_calc ? drv_b : alu_b_reg;
    assign bus.alu_c_o   = in_calc ? drv_c : alu_c_reg;
    assign bus.res_hi_o  = res_hi_reg;
    assign bus.res_lo_o  = res_lo_reg;

    // Sequencer and datapath: accept in IDLE, N iterations in CALC, one DONE cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            op_reg     <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opb_reg    <= '0;
            res_hi_reg <= '0;
            res_lo_reg <= '0;
            alu_a_reg  <= '0;
            alu_b_reg  <= '0;
            alu_c_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.valid_i) begin
                        op_reg    <= bus.op_i;
                        cnt_reg   <= '0;
                        hi_reg    <= '0;
                        // The multiplier shifts out through lo; the dividend shifts out through lo.
                        lo_reg    <= bus.op_i ? bus.a_i : bus.b_i;
                        opb_reg   <= bus.op_i ? bus.b_i : bus.a_i;
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    hi_reg    <= hi_next;
                    lo_reg    <= lo_next;
                    alu_a_reg <= drv_a;
                    alu_b_reg <= drv_b;
                    alu_c_reg <= drv_c;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_iter) begin
                        res_hi_reg <= hi_next;
                        res_lo_reg <= lo_next;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq. A behavioural shared ALU is attached to the ALU port.
module tb_alu_muldiv_seq;
    localparam int N = 32;

    logic clk_i;
    logic rst_ni;
    int   checks;
    int   errors;

    alu_muldiv_seq_if #(.N(N)) bus ();

    alu_muldiv_seq #(.N(N), .OPC_ADD(4'b0010)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    // Shared ALU: add, or subtract via inverted B plus carry-in.
    logic [N:0] alu_sum;
    assign alu_sum       = {1'b0, bus.alu_a_o}
                         + {1'b0, (bus.alu_c_o ? ~bus.alu_b_o : bus.alu_b_o)}
                         + {{N{1'b0}}, bus.alu_c_o};
    assign bus.alu_sal_i = alu_sum[N-1:0];
    assign bus.alu_co_i  = alu_sum[N];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one request and wait for done_o.
    // Check latency, ALU ownership length, opcode and results.
    task automatic run_op(input string tag, input logic op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] exp_hi,
                          input logic [N-1:0] exp_lo);
        int lat;
        int own_cnt;
        @(negedge clk_i);
        check({tag, "_ready"}, 64'(bus.ready_o), 64'd1);
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        bus.valid_i = 1'b1;
        @(posedge clk_i);
        #1 bus.valid_i = 1'b0;
        lat     = 0;
        own_cnt = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk_i);
            if (bus.alu_own_o) begin
                own_cnt++;
                if (bus.alu_ope_o !== 4'b0010) check({tag, "_ope"}, 64'(bus.alu_ope_o), 64'h2);
            end
            if (bus.done_o) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd33);
        check({tag, "_own_cycles"}, 64'(own_cnt), 64'd32);
        check({tag, "_res"}, {bus.res_hi_o, bus.res_lo_o}, {exp_hi, exp_lo});
        @(negedge clk_i);
        check({tag, "_done_1cyc"}, {63'd0, bus.done_o}, 64'd0);
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", op, a, b,
                 bus.res_hi_o, bus.res_lo_o, lat);
    endtask

    initial begin
        int saw_done;
        checks      = 0;
        errors      = 0;
        rst_ni      = 1'b0;
        bus.valid_i = 1'b0;
        bus.op_i    = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", 64'(bus.ready_o), 64'd1);
        check("rst_done_own", {62'd0, bus.done_o, bus.alu_own_o}, 64'd0);
        check("rst_res", {bus.res_hi_o, bus.res_lo_o}, 64'd0);
        check("rst_alu", {bus.alu_a_o, bus.alu_b_o}, 64'd0);
        check("rst_alu_c", 64'(bus.alu_c_o), 64'd0);
        rst_ni = 1'b1;

        run_op("mul_7x6",   1'b0, 32'd7,          32'd6,          32'd0,          32'd42);
        run_op("mul_max",   1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001);
        run_op("div_100_7", 1'b1, 32'd100,        32'd7,          32'd2,          32'd14);
        run_op("div_big",   1'b1, 32'h8000_0000,  32'h8000_0001,  32'h8000_0000,  32'd0);
        run_op("div_by1",   1'b1, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF);
        run_op("div_by0",   1'b1, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF);
        check("hold_alu_c", 64'(bus.alu_c_o), 64'd1);

        // A request raised during CALC is ignored and then accepted right after DONE.
        @(negedge clk_i);
        bus.op_i = 1'b1; bus.a_i = 32'd100; bus.b_i = 32'd7; bus.valid_i = 1'b1;
        @(posedge clk_i);
        #1 bus.op_i = 1'b0; bus.a_i = 32'd3; bus.b_i = 32'd5;
        repeat (5) @(negedge clk_i);
        check("busy_ready", 64'(bus.ready_o), 64'd0);
        saw_done = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (bus.done_o) begin
                saw_done = 1;
                break;
            end
        end
        check("busy_done_seen", 64'(saw_done), 64'd1);
        check("busy_res_unchanged", {bus.res_hi_o, bus.res_lo_o}, {32'd2, 32'd14});
        @(negedge clk_i);
        check("held_ready_after_done", 64'(bus.ready_o), 64'd1);
        @(posedge clk_i);
        #1 bus.valid_i = 1'b0;
        check("held_accepted", {62'd0, bus.ready_o, bus.alu_own_o}, 64'd1);
        saw_done = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (bus.done_o) begin
                saw_done = 1;
                break;
            end
        end
        check("held_done_seen", 64'(saw_done), 64'd1);
        check("held_res", {bus.res_hi_o, bus.res_lo_o}, {32'd0, 32'd15});
        $display("held request 3*5 -> hi=%h lo=%h", bus.res_hi_o, bus.res_lo_o);

        // Asynchronous reset at CALC iteration 10 aborts the operation without a done pulse.
        @(negedge clk_i);
        bus.op_i = 1'b0; bus.a_i = 32'hFFFF_FFFF; bus.b_i = 32'hFFFF_FFFF; bus.valid_i = 1'b1;
        @(posedge clk_i);
        #1 bus.valid_i = 1'b0;
        repeat (11) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check("abort_ready", 64'(bus.ready_o), 64'd1);
        check("abort_own_done", {62'd0, bus.alu_own_o, bus.done_o}, 64'd0);
        check("abort_res", {bus.res_hi_o, bus.res_lo_o}, 64'd0);
        check("abort_alu", {bus.alu_a_o, bus.alu_b_o}, 64'd0);
        saw_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk_i);
            if (bus.done_o) saw_done = 1;
            if (n == 3) rst_ni = 1'b1;
        end
        check("abort_no_done", 64'(saw_done), 64'd0);
        $display("reset abort during CALC: done seen=%0d", saw_done);

        run_op("mul_3x5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
